// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce bank: repeat FSM encoding and a width helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int width_for(input longint max_val);
    int w;
    w = 1;
    while ((longint'(1) << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, stability-count debounce, edge strobes and auto-repeat FSM.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_RATE   = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_raw,
  input  logic       repeat_en,
  output logic       level,
  output logic       press,
  output logic       release_strb,
  output logic       repeating,
  output logic [1:0] state_dbg
);

  localparam int MAX_TMR = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW      = width_for(longint'(STABLE_CYCLES));
  localparam int TW      = width_for(longint'(MAX_TMR));

  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [TW-1:0]          tmr_q, tmr_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   repeating_q, repeating_d;
  rep_state_e             state_q, state_d;

  logic s;
  logic accept_rise;
  logic accept_fall;
  logic rep_tick;

  // Pure shift chain: nothing combinational between synchroniser flops.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_raw};
    s      = sync_q[SYNC_STAGES-1];
  end

  // A disagreement must persist for STABLE_CYCLES edges; any agreement clears the count.
  always_comb begin
    level_d     = level_q;
    cnt_d       = cnt_q;
    accept_rise = 1'b0;
    accept_fall = 1'b0;
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d     = s;
      cnt_d       = '0;
      accept_rise = s;
      accept_fall = ~s;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    rep_tick = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_rise && repeat_en) begin
          state_d = ST_DELAY;
          tmr_d   = '0;
        end
      end
      ST_DELAY: begin
        if (tmr_q == DELAY_LAST) begin
          state_d  = ST_REPEAT;
          tmr_d    = '0;
          rep_tick = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (tmr_q == RATE_LAST) begin
          tmr_d    = '0;
          rep_tick = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
    endcase
    // Release or disable wins over a timer expiring on the same edge.
    if (accept_fall || !repeat_en) begin
      state_d  = ST_IDLE;
      tmr_d    = '0;
      rep_tick = 1'b0;
    end
  end

  always_comb begin
    press_d     = accept_rise | rep_tick;
    release_d   = accept_fall;
    repeating_d = (state_d == ST_REPEAT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      repeating_q <= 1'b0;
      state_q     <= ST_IDLE;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      repeating_q <= repeating_d;
      state_q     <= state_d;
    end
  end

  assign level        = level_q;
  assign press        = press_q;
  assign release_strb = release_q;
  assign repeating    = repeating_q;
  assign state_dbg    = state_q;

endmodule

// File: rtl/debounce_bank.sv
// N independent button channels; the top only fans ports out to per-channel conditioners.
// release_strb carries the accepted 1->0 strobe (release is a reserved word).
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS      = 5,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_RATE   = 10_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   in,
  input  logic [CHANNELS-1:0]   repeat_en,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   press,
  output logic [CHANNELS-1:0]   release_strb,
  output logic [CHANNELS-1:0]   repeating,
  output logic [2*CHANNELS-1:0] dbg_state
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_raw      (in[i]),
      .repeat_en   (repeat_en[i]),
      .level       (level[i]),
      .press       (press[i]),
      .release_strb(release_strb[i]),
      .repeating   (repeating[i]),
      .state_dbg   (dbg_state[2*i +: 2])
    );
  end

endmodule
